// File: rtl/spi_command_queue_if.sv
// spi_command_queue_if
//   Groups the two handshakes around the command queue.
//   SPI side : spi_data / spi_data_valid in, spi_clear acknowledge out.
//   Cmd side : cmd_valid + decoded head fields out, cmd_ready in.
//   slave  modport : used by the queue itself.
//   master modport : used by whatever drives the SPI bytes and consumes commands.
interface spi_command_queue_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] spi_data;
  logic                  spi_data_valid;
  logic                  spi_clear;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_move;
  logic [2:0]            cmd_piece;
  logic                  cmd_move_valid;

  modport slave (
    input  spi_data, spi_data_valid, cmd_ready,
    output spi_clear, cmd_valid, cmd_move, cmd_piece, cmd_move_valid
  );

  modport master (
    output spi_data, spi_data_valid, cmd_ready,
    input  spi_clear, cmd_valid, cmd_move, cmd_piece, cmd_move_valid
  );
endinterface

// File: rtl/spi_command_queue.sv
// spi_command_queue
//   Captures bytes from the SPI slave into a first-word-fall-through FIFO,
//   decodes the head into move / piece / valid fields for the game
//   executioner, produces the SPI clear pulse, a one-cycle game tick enable
//   and telemetry counters. Single clock domain, synchronous active-high reset.
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   bus (slave)         : spi_data/spi_data_valid/spi_clear, cmd_valid/cmd_ready,
//                         cmd_move/cmd_piece/cmd_move_valid
//   game_tick           : one-cycle enable every TICK_DIV cycles
//   fifo_count          : FIFO occupancy 0..DEPTH
//   telemetry_accepted  : bytes pushed (wraps)
//   telemetry_dropped   : bytes lost to a full FIFO (saturates)
//   telemetry_ticks     : game ticks issued (wraps)
// Parameter constraints: DATA_WIDTH >= 6, DEPTH power of two >= 2, TICK_DIV >= 2.
module spi_command_queue #(
  parameter int DATA_WIDTH            = 8,
  parameter int DEPTH                 = 4,
  parameter int TICK_DIV              = 30000000,
  parameter int TELEMETRY_VALUE_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  spi_command_queue_if.slave               bus,
  output logic                             game_tick,
  output logic [$clog2(DEPTH):0]           fifo_count,
  output logic [TELEMETRY_VALUE_WIDTH-1:0] telemetry_accepted,
  output logic [TELEMETRY_VALUE_WIDTH-1:0] telemetry_dropped,
  output logic [TELEMETRY_VALUE_WIDTH-1:0] telemetry_ticks
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int CMD_W = 6;  // only byte bits [5:0] carry meaning

  typedef struct packed {
    logic       move_valid;
    logic [2:0] piece;
    logic [1:0] move;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLEAR    = 2'd1,
    WAIT_LOW = 2'd2
  } cap_state_t;

  // ---------------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------------
  cap_state_t state, state_nxt;
  logic       capture;
  logic       clear_pulse;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (bus.spi_data_valid)  state_nxt = CLEAR;
      CLEAR:                             state_nxt = WAIT_LOW;
      // spi_data_valid is a level held until the slave sees the clear; wait
      // for it to drop so the same byte is not captured twice.
      WAIT_LOW: if (!bus.spi_data_valid) state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  always_comb begin
    capture     = 1'b0;
    clear_pulse = 1'b0;
    case (state)
      IDLE:    capture     = bus.spi_data_valid;
      CLEAR:   clear_pulse = 1'b1;
      default: ;
    endcase
  end

  // Reset lands on the clock edge, so the state may still read CLEAR during
  // the reset cycle; mask it so spi never sees an ack while we are in reset.
  assign bus.spi_clear = clear_pulse & ~reset;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [CMD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, pop, push, drop;

  assign bus.cmd_valid = (fifo_count != '0);
  assign full          = (fifo_count == CNT_W'(DEPTH));
  assign pop           = bus.cmd_valid & bus.cmd_ready;
  // A pop in the same cycle frees a slot, so a push onto a full FIFO is
  // still accepted when the consumer is taking the head.
  assign push          = capture & (~full | pop);
  assign drop          = capture & full & ~pop;

  // Storage carries no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.spi_data[CMD_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  generate
    if (DATA_WIDTH > CMD_W) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^bus.spi_data[DATA_WIDTH-1:CMD_W];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Head decode
  // ---------------------------------------------------------------------------
  logic [CMD_W-1:0] head_byte;
  cmd_t             head_cmd, held_cmd, out_cmd;

  assign head_byte           = mem[rd_ptr];
  assign head_cmd.move       = head_byte[1:0];
  // Piece code 7 is not a real piece; it maps onto HERO (0).
  assign head_cmd.piece      = (head_byte[4:2] == 3'b111) ? 3'd0 : head_byte[4:2];
  assign head_cmd.move_valid = head_byte[5];

  // When the FIFO drains, keep presenting the last head instead of whatever
  // stale entry the read pointer now lands on.
  always_ff @(posedge clk) begin
    if (reset)              held_cmd <= '0;
    else if (bus.cmd_valid) held_cmd <= head_cmd;
  end

  assign out_cmd            = bus.cmd_valid ? head_cmd : held_cmd;
  assign bus.cmd_move       = out_cmd.move;
  assign bus.cmd_piece      = out_cmd.piece;
  assign bus.cmd_move_valid = out_cmd.move_valid;

  // ---------------------------------------------------------------------------
  // Game tick divider
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic             tick_hit;

  assign tick_hit  = (div_cnt == DIV_W'(TICK_DIV - 1));
  assign game_tick = tick_hit & ~reset;

  always_ff @(posedge clk) begin
    if (reset)         div_cnt <= '0;
    else if (tick_hit) div_cnt <= '0;
    else               div_cnt <= div_cnt + DIV_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Telemetry
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      telemetry_accepted <= '0;
      telemetry_dropped  <= '0;
      telemetry_ticks    <= '0;
    end else begin
      if (push)
        telemetry_accepted <= telemetry_accepted + TELEMETRY_VALUE_WIDTH'(1);
      if (drop && (telemetry_dropped != '1))
        telemetry_dropped  <= telemetry_dropped + TELEMETRY_VALUE_WIDTH'(1);
      if (tick_hit)
        telemetry_ticks    <= telemetry_ticks + TELEMETRY_VALUE_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_spi_command_queue.sv
// Directed bench for spi_command_queue (DEPTH=4, TICK_DIV=5).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_spi_command_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       game_tick;
  logic [2:0] fifo_count;
  logic [7:0] telemetry_accepted, telemetry_dropped, telemetry_ticks;

  int tests = 0;
  int fails = 0;
  int pulses;

  spi_command_queue_if #(.DATA_WIDTH(8)) bus ();

  spi_command_queue #(
    .DATA_WIDTH(8), .DEPTH(4), .TICK_DIV(5), .TELEMETRY_VALUE_WIDTH(8)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .bus                (bus),
    .game_tick          (game_tick),
    .fifo_count         (fifo_count),
    .telemetry_accepted (telemetry_accepted),
    .telemetry_dropped  (telemetry_dropped),
    .telemetry_ticks    (telemetry_ticks)
  );

  always #5 clk = ~clk;

  // {move_valid, piece, move} hand-decoded for each byte used below
  logic [7:0] bytes [6] = '{8'h21, 8'h06, 8'h2B, 8'h10, 8'h35, 8'h3E};
  logic [5:0] dec   [6] = '{6'b1_000_01, 6'b0_001_10, 6'b1_010_11,
                            6'b0_100_00, 6'b1_101_01, 6'b1_000_10};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] head();
    return 32'({bus.cmd_move_valid, bus.cmd_piece, bus.cmd_move});
  endfunction

  // One byte: valid for one cycle, then low long enough to return to IDLE.
  task automatic send_byte(input logic [7:0] b);
    bus.spi_data       = b;
    bus.spi_data_valid = 1'b1;
    step(1);
    bus.spi_data_valid = 1'b0;
    step(2);
  endtask

  task automatic pop_one();
    bus.cmd_ready = 1'b1;
    step(1);
    bus.cmd_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    reset              = 1'b1;
    bus.spi_data       = '0;
    bus.spi_data_valid = 1'b0;
    bus.cmd_ready      = 1'b0;
    step(2);

    // ---- reset state
    check("rst_count",    32'(fifo_count), 32'd0);
    check("rst_valid",    32'(bus.cmd_valid), 32'd0);
    check("rst_clear",    32'(bus.spi_clear), 32'd0);
    check("rst_tick",     32'(game_tick), 32'd0);
    check("rst_head",     head(), 32'd0);
    check("rst_accepted", 32'(telemetry_accepted), 32'd0);
    check("rst_dropped",  32'(telemetry_dropped), 32'd0);
    check("rst_ticks",    32'(telemetry_ticks), 32'd0);
    reset = 1'b0;

    // ---- 1: byte held high 5 cycles -> one clear, one push
    bus.spi_data       = 8'b0010_1101;
    bus.spi_data_valid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (i == 0) begin
        check("t1_clear_n1", 32'(bus.spi_clear), 32'd1);
        check("t1_count_n1", 32'(fifo_count), 32'd1);
      end
      if (bus.spi_clear) pulses++;
    end
    check("t1_pulses", 32'(pulses), 32'd1);
    bus.spi_data_valid = 1'b0;
    step(2);
    check("t1_head",     head(), 32'(6'b1_011_01));
    check("t1_count",    32'(fifo_count), 32'd1);
    check("t1_accepted", 32'(telemetry_accepted), 32'd1);
    pop_one();
    check("t1_empty",    32'(bus.cmd_valid), 32'd0);
    check("t1_held",     head(), 32'(6'b1_011_01));
    pop_one();  // ready while empty: no effect
    check("t1_empty_pop", 32'(fifo_count), 32'd0);

    // ---- 2: six pushes into depth 4 -> two drops, FIFO order on pop
    for (int i = 0; i < 6; i++) send_byte(bytes[i]);
    check("t2_count",    32'(fifo_count), 32'd4);
    check("t2_dropped",  32'(telemetry_dropped), 32'd2);
    check("t2_accepted", 32'(telemetry_accepted), 32'd5);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_pop%0d_valid", i), 32'(bus.cmd_valid), 32'd1);
      check($sformatf("t2_pop%0d_head", i), head(), 32'(dec[i]));
      pop_one();
    end
    check("t2_drained", 32'(bus.cmd_valid), 32'd0);
    check("t2_held",    head(), 32'(dec[3]));

    // ---- 3: push while full with simultaneous pop is accepted
    for (int i = 0; i < 4; i++) send_byte(bytes[i]);
    check("t3_full", 32'(fifo_count), 32'd4);
    bus.spi_data       = bytes[5];
    bus.spi_data_valid = 1'b1;
    bus.cmd_ready      = 1'b1;
    step(1);
    bus.cmd_ready      = 1'b0;
    bus.spi_data_valid = 1'b0;
    step(2);
    check("t3_count",    32'(fifo_count), 32'd4);
    check("t3_dropped",  32'(telemetry_dropped), 32'd2);
    check("t3_accepted", 32'(telemetry_accepted), 32'd10);
    for (int i = 0; i < 4; i++) begin
      // expected order: bytes 1,2,3 then the coincident byte (piece 7 -> 0)
      check($sformatf("t3_pop%0d_head", i), head(), 32'(dec[(i == 3) ? 5 : i + 1]));
      pop_one();
    end
    check("t3_drained", 32'(bus.cmd_valid), 32'd0);

    // ---- 4: dropped counter saturates
    for (int i = 0; i < 4; i++) send_byte(8'h01);
    for (int i = 0; i < 253; i++) send_byte(8'hFF);
    check("t4_dropped_255", 32'(telemetry_dropped), 32'd255);
    for (int i = 0; i < 7; i++) send_byte(8'hFF);
    check("t4_dropped_sat", 32'(telemetry_dropped), 32'd255);
    check("t4_accepted",    32'(telemetry_accepted), 32'd14);
    check("t4_count",       32'(fifo_count), 32'd4);

    // ---- 5: tick at cycles 4, 9, 14 after reset
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    for (int c = 0; c < 16; c++) begin
      check($sformatf("t5_tick_c%0d", c), 32'(game_tick),
            32'((c == 4) || (c == 9) || (c == 14)));
      if (c == 15) check("t5_ticks", 32'(telemetry_ticks), 32'd3);
      step(1);
    end
    // reset in cycle 7 restarts the divider: next tick at cycle 12
    do_reset();
    for (int c = 0; c < 14; c++) begin
      check($sformatf("t5r_tick_c%0d", c), 32'(game_tick),
            32'((c == 4) || (c == 12)));
      if (c == 13) check("t5r_ticks", 32'(telemetry_ticks), 32'd1);
      if (c == 7) reset = 1'b1;
      if (c == 8) reset = 1'b0;
      step(1);
    end

    // ---- 6: reset during CLEAR with entries queued
    do_reset();
    send_byte(bytes[0]);
    send_byte(bytes[1]);
    check("t6_count2", 32'(fifo_count), 32'd2);
    bus.spi_data       = bytes[2];
    bus.spi_data_valid = 1'b1;
    step(1);
    check("t6_in_clear", 32'(bus.spi_clear), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_clear_in_reset", 32'(bus.spi_clear), 32'd0);
    step(1);
    check("t6_count0", 32'(fifo_count), 32'd0);
    check("t6_valid0", 32'(bus.cmd_valid), 32'd0);
    check("t6_clear0", 32'(bus.spi_clear), 32'd0);
    check("t6_head0",  head(), 32'd0);
    reset = 1'b0;
    step(1);
    check("t6_recapture_clear", 32'(bus.spi_clear), 32'd1);
    check("t6_recapture_count", 32'(fifo_count), 32'd1);
    check("t6_recapture_head",  head(), 32'(dec[2]));
    step(3);
    check("t6_once_count",    32'(fifo_count), 32'd1);
    check("t6_once_accepted", 32'(telemetry_accepted), 32'd1);
    check("t6_once_clear",    32'(bus.spi_clear), 32'd0);
    bus.spi_data_valid = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
